// File: rtl/regfile_pkg.sv
// Shared types for the register-file read sequencer.
// Widths, address/data typedefs and the sequencer state encoding.
package regfile_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef logic [XLEN-1:0]    xlen_t;
  typedef logic [RADDR_W-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    CAP2,
    HOLD
  } rseq_state_t;

endpackage

// File: rtl/regfile_read_sequencer_operand_slot.sv
// One operand register with forward/bypass/capture priority.
// An operand addressed to x0 never leaves zero.
module operand_slot #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               track,
  input  logic               cap,
  input  logic [RADDR_W-1:0] rs,
  input  logic               wb_valid,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               wbq_valid,
  input  logic [RADDR_W-1:0] wbq_rd,
  input  logic [XLEN-1:0]    wbq_data,
  input  logic [XLEN-1:0]    rf_read_data,
  output logic [XLEN-1:0]    data
);

  import regfile_pkg::*;

  logic rs_nz;
  logic hit_wb;
  logic hit_q;
  logic [XLEN-1:0] cap_val;

  always_comb begin
    rs_nz  = (rs != '0);
    hit_wb = track && wb_valid
             && (wb_rd == rs) && rs_nz;
    hit_q  = wbq_valid
             && (wbq_rd == rs) && rs_nz;
    cap_val = rf_read_data;
    if (!rs_nz) begin
      cap_val = '0;
    end else if (hit_q) begin
      // read port missed the write that landed on its edge
      cap_val = wbq_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (hit_wb) begin
      data <= wb_data;
    end else if (cap) begin
      data <= cap_val;
    end
  end

endmodule

// File: rtl/regfile_read_sequencer.sv
// Two-operand fetch through a single registered read port,
// with writeback muxing and forwarding into held operands.
module regfile_read_sequencer #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [RADDR_W-1:0] req_rs1,
  input  logic [RADDR_W-1:0] req_rs2,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [XLEN-1:0]    op_rs1_data,
  output logic [XLEN-1:0]    op_rs2_data,
  input  logic               wb_valid,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic [RADDR_W-1:0] rf_read_select,
  input  logic [XLEN-1:0]    rf_read_data,
  output logic [RADDR_W-1:0] rf_write_select,
  output logic [XLEN-1:0]    rf_write_data
);

  import regfile_pkg::*;

  rseq_state_t state_q;
  rseq_state_t state_d;

  logic [RADDR_W-1:0] rs1_q;
  logic [RADDR_W-1:0] rs2_q;

  logic               wbq_valid;
  logic [RADDR_W-1:0] wbq_rd;
  logic [XLEN-1:0]    wbq_data;

  logic accept;
  logic track;
  logic cap1;
  logic cap2;

  // no writes reach the file while reset is held
  assign rf_write_select =
    (wb_valid && !reset) ? wb_rd : '0;
  assign rf_write_data =
    (wb_valid && !reset) ? wb_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      wbq_valid <= 1'b0;
      wbq_rd    <= '0;
      wbq_data  <= '0;
    end else begin
      state_q   <= state_d;
      wbq_valid <= wb_valid;
      wbq_rd    <= wb_rd;
      wbq_data  <= wb_data;
      if (accept) begin
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    op_valid       = 1'b0;
    rf_read_select = '0;
    accept         = 1'b0;
    track          = 1'b0;
    cap1           = 1'b0;
    cap2           = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = RD1;
        end
      end
      RD1: begin
        rf_read_select = rs1_q;
        track          = 1'b1;
        state_d        = RD2;
      end
      RD2: begin
        rf_read_select = rs2_q;
        track          = 1'b1;
        cap1           = 1'b1;
        state_d        = CAP2;
      end
      CAP2: begin
        track   = 1'b1;
        cap2    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        track    = 1'b1;
        op_valid = 1'b1;
        if (op_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  operand_slot #(
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W)
  ) u_op1 (
    .clk          (clk),
    .reset        (reset),
    .track        (track),
    .cap          (cap1),
    .rs           (rs1_q),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wbq_valid    (wbq_valid),
    .wbq_rd       (wbq_rd),
    .wbq_data     (wbq_data),
    .rf_read_data (rf_read_data),
    .data         (op_rs1_data)
  );

  operand_slot #(
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W)
  ) u_op2 (
    .clk          (clk),
    .reset        (reset),
    .track        (track),
    .cap          (cap2),
    .rs           (rs2_q),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wbq_valid    (wbq_valid),
    .wbq_rd       (wbq_rd),
    .wbq_data     (wbq_data),
    .rf_read_data (rf_read_data),
    .data         (op_rs2_data)
  );

endmodule

// File: tb/tb_regfile_read_sequencer.sv
// Bench for regfile_read_sequencer: directed plus random traffic
// against an architectural register model and a transaction age.
module tb_regfile_read_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_rs1_data;
  logic [31:0] op_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rf_read_select;
  logic [31:0] rf_read_data;
  logic [4:0]  rf_write_select;
  logic [31:0] rf_write_data;

  int n_cmp = 0;
  int n_bad = 0;

  // architectural view: value of each register after all prior writes
  logic [31:0] arch [32];
  bit          outst;
  int          age;
  logic [4:0]  m_rs1;
  logic [4:0]  m_rs2;

  // register file: registered read, write port always enabled
  logic [31:0] mem [32];

  always #5 clk = ~clk;

  regfile_read_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_rs1         (req_rs1),
    .req_rs2         (req_rs2),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .op_rs1_data     (op_rs1_data),
    .op_rs2_data     (op_rs2_data),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .rf_read_select  (rf_read_select),
    .rf_read_data    (rf_read_data),
    .rf_write_select (rf_write_select),
    .rf_write_data   (rf_write_data)
  );

  always @(posedge clk) begin
    if (rf_write_select != 5'd0)
      mem[rf_write_select] <= rf_write_data;
    rf_read_data <= mem[rf_read_select];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [4:0] esel;
    logic       eopv;
    esel = 5'd0;
    if (outst && age == 1) esel = m_rs1;
    if (outst && age == 2) esel = m_rs2;
    eopv = outst && (age >= 4);
    chk("req_ready", {31'd0, req_ready}, {31'd0, !outst});
    chk("op_valid", {31'd0, op_valid}, {31'd0, eopv});
    chk("rf_read_select", {27'd0, rf_read_select}, {27'd0, esel});
    chk("rf_write_select", {27'd0, rf_write_select},
        wb_valid ? {27'd0, wb_rd} : 32'd0);
    chk("rf_write_data", rf_write_data,
        wb_valid ? wb_data : 32'd0);
    if (eopv) begin
      chk("op_rs1_data", op_rs1_data, arch[m_rs1]);
      chk("op_rs2_data", op_rs2_data, arch[m_rs2]);
    end
  endtask

  task automatic model_edge();
    bit hs;
    hs = outst && (age >= 4) && op_ready;
    if (wb_valid && wb_rd != 5'd0) arch[wb_rd] = wb_data;
    if (outst) begin
      if (hs) outst = 1'b0;
      else if (age < 4) age++;
    end else if (req_valid) begin
      outst = 1'b1;
      age   = 1;
      m_rs1 = req_rs1;
      m_rs2 = req_rs2;
    end
  endtask

  task automatic step(input logic wv, input logic [4:0] wrd,
                      input logic [31:0] wd, input logic rv,
                      input logic [4:0] a, input logic [4:0] b,
                      input logic ordy);
    wb_valid  = wv;
    wb_rd     = wrd;
    wb_data   = wd;
    req_valid = rv;
    req_rs1   = a;
    req_rs2   = b;
    op_ready  = ordy;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    wb_valid  = 1'b1;
    wb_rd     = 5'd4;
    wb_data   = 32'hDEAD_BEEF;
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    chk("rst op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst rf_write_select", {27'd0, rf_write_select}, 32'd0);
    chk("rst rf_write_data", rf_write_data, 32'd0);
    chk("rst rf_read_select", {27'd0, rf_read_select}, 32'd0);
    @(posedge clk);
    outst = 1'b0;
    #1;
    reset    = 1'b0;
    wb_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]  = 32'd0;
      arch[i] = 32'd0;
    end
    rf_read_data = 32'd0;
    outst = 1'b0;
    age   = 0;
    m_rs1 = 5'd0;
    m_rs2 = 5'd0;
    req_valid = 1'b0;
    req_rs1   = 5'd0;
    req_rs2   = 5'd0;
    op_ready  = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
    reset     = 1'b1;
    #1;
    chk("init op_valid", {31'd0, op_valid}, 32'd0);
    chk("init req_ready", {31'd0, req_ready}, 32'd1);
    chk("init op_rs1_data", op_rs1_data, 32'd0);
    chk("init op_rs2_data", op_rs2_data, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // plain fetch of two preloaded registers
    step(1, 5, 32'h11, 0, 0, 0, 0);
    step(1, 6, 32'h22, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5, 6, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // x0 operands under a stream of x0 writes
    step(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1);

    // write racing the first read, same register twice
    step(1, 7, 32'h1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 7, 7, 0);
    step(1, 7, 32'hAB, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // forwarding into a held operand
    step(1, 8, 32'h3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 8, 2, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 8, 32'h99, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // reset in the middle of a sequence
    step(0, 0, 0, 1, 5, 6, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    pulse_reset();
    step(0, 0, 0, 1, 6, 5, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);

    // write in the handshake cycle is not seen by that handshake
    step(1, 9, 32'h77, 0, 0, 0, 0);
    step(0, 0, 0, 1, 9, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
    step(1, 9, 32'h5, 0, 0, 0, 1);
    step(0, 0, 0, 1, 9, 9, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);

    // random traffic over a small register window
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 7)),
           $urandom,
           ($urandom_range(0, 2) != 0),
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)),
           ($urandom_range(0, 4) > 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
